// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers and stall request.
// Define MULDIV_SIGNED_EN to make op 00/10 signed; otherwise all ops are unsigned.
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            hilo_rd,
   input  logic            hi_wr,
   input  logic            lo_wr,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            done,
   output logic            stall
);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

   state_t            state, state_nxt;
   logic [5:0]        cnt;
   logic              is_div, divz;
   logic [XLEN-1:0]   m, r, q, a_raw;
   logic [XLEN-1:0]   a_mag, b_mag, quo_f, rem_f;
   logic [2*XLEN-1:0] prod, prod_f;
   logic [XLEN:0]     mul_sum, div_t;
   logic              div_ge;
   logic [XLEN-1:0]   hi_f, lo_f;
   logic              accept;

   assign accept = (state == IDLE) & start;
   assign prod   = {r, q};

`ifdef MULDIV_SIGNED_EN
   logic sa, sb, neg_q, neg_r;

   assign sa    = ~op[0] & a[XLEN-1];
   assign sb    = ~op[0] & b[XLEN-1];
   assign a_mag = sa ? -a : a;
   assign b_mag = sb ? -b : b;

   always_ff @(posedge clk) begin
      if (reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept) begin
         neg_q <= sa ^ sb;
         neg_r <= sa;
      end
   end

   assign prod_f = neg_q ? -prod : prod;
   assign quo_f  = neg_q ? -q : q;
   assign rem_f  = neg_r ? -r : r;
`else
   logic unused_op;

   assign unused_op = op[0];
   assign a_mag     = a;
   assign b_mag     = b;
   assign prod_f    = prod;
   assign quo_f     = q;
   assign rem_f     = r;
`endif

   // Mult: {r,q} shifts right with the sum; div: {r,q} shifts left, restoring.
   assign mul_sum = {1'b0, r} + (q[0] ? {1'b0, m} : '0);
   assign div_t   = {r, q[XLEN-1]};
   assign div_ge  = div_t >= {1'b0, m};

   assign hi_f = is_div ? (divz ? a_raw : rem_f) : prod_f[2*XLEN-1:XLEN];
   assign lo_f = is_div ? (divz ? '1 : quo_f) : prod_f[XLEN-1:0];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (cnt == 6'd0) state_nxt = FIXUP;
         FIXUP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy  = state != IDLE;
      stall = busy & (start | hilo_rd | hi_wr | lo_wr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         cnt    <= 6'd0;
         is_div <= 1'b0;
         divz   <= 1'b0;
         m      <= '0;
         r      <= '0;
         q      <= '0;
         a_raw  <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  is_div <= op[1];
                  divz   <= b == '0;
                  m      <= b_mag;
                  q      <= a_mag;
                  r      <= '0;
                  a_raw  <= a;
                  cnt    <= 6'd31;
               end else begin
                  if (hi_wr) hi <= wr_data;
                  if (lo_wr) lo <= wr_data;
               end
            end
            CALC: begin
               if (cnt != 6'd0) cnt <= cnt - 6'd1;
               if (is_div) begin
                  r <= div_ge ? div_t[XLEN-1:0] - m : div_t[XLEN-1:0];
                  q <= {q[XLEN-2:0], div_ge};
               end else begin
                  r <= mul_sum[XLEN:1];
                  q <= {mul_sum[0], q[XLEN-1:1]};
               end
            end
            FIXUP: begin
               hi   <= hi_f;
               lo   <= lo_f;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
// Signed expectations apply when MULDIV_SIGNED_EN is defined.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, hilo_rd, hi_wr, lo_wr;
   logic [1:0]  op;
   logic [31:0] a, b, wr_data, hi, lo;
   logic        busy, done, stall;

   int n_assert = 0;
   int n_fail   = 0;
   int errs;

   always #5 clk = ~clk;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hilo_rd(hilo_rd), .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Start is sampled at E0; returns #1 into cycle 1.
   task automatic issue(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Cycles 1-33 busy without done; returns at negedge of cycle 34.
   task automatic run(input string tag);
      int bad = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (busy !== 1'b1 || done !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk({tag, "_busy_window"}, bad, 0);
      chk({tag, "_busy34"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done34"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hilo_rd = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("multu_max");
      chk("multu_max_hi", hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", lo, 32'h0000_0001);

      // Issued from cycle 34: back-to-back start
      issue(2'b00, 32'hFFFF_FFFD, 32'd7);
      run("mult");
`ifdef MULDIV_SIGNED_EN
      chk("mult_hi", hi, 32'hFFFF_FFFF);
`else
      chk("mult_hi", hi, 32'h0000_0006);
`endif
      chk("mult_lo", lo, 32'hFFFF_FFEB);

      issue(2'b10, 32'hFFFF_FFF9, 32'd2);
      run("div");
`ifdef MULDIV_SIGNED_EN
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
`else
      chk("div_lo", lo, 32'h7FFF_FFFC);
      chk("div_hi", hi, 32'h0000_0001);
`endif

      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run("ovf");
`ifdef MULDIV_SIGNED_EN
      chk("ovf_lo", lo, 32'h8000_0000);
      chk("ovf_hi", hi, 32'h0000_0000);
`else
      chk("ovf_lo", lo, 32'h0000_0000);
      chk("ovf_hi", hi, 32'h8000_0000);
`endif

      issue(2'b10, 32'hFFFF_FFFB, 32'd0);
      run("sdivz");
      chk("sdivz_hi", hi, 32'hFFFF_FFFB);
      chk("sdivz_lo", lo, 32'hFFFF_FFFF);

      issue(2'b11, 32'd100, 32'd0);
      run("divz");
      chk("divz_hi", hi, 32'd100);
      chk("divz_lo", lo, 32'hFFFF_FFFF);

      // divu 100/7 with mflo from cycle 5, second start in cycles 10-11
      issue(2'b11, 32'd100, 32'd7);
      errs = 0;
      for (int k = 1; k <= 33; k++) begin
         if (k == 5) hilo_rd = 1'b1;
         if (k == 10) begin start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1; end
         if (k == 12) start = 1'b0;
         @(negedge clk);
         if (stall !== (k >= 5)) errs++;
         if (busy !== 1'b1 || done !== 1'b0) errs++;
         if (hi !== 32'd100 || lo !== 32'hFFFF_FFFF) errs++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("stall_window", errs, 0);
      chk("stall34", {31'd0, stall}, 32'd0);
      chk("divu_done34", {31'd0, done}, 32'd1);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      hilo_rd = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("no_restart_busy", {31'd0, busy}, 32'd0);

      // mthi in IDLE
      hi_wr = 1'b1; wr_data = 32'h1234;
      @(posedge clk); #1;
      hi_wr = 1'b0;
      @(negedge clk);
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_lo", lo, 32'd14);
      chk("mthi_nodone", {31'd0, done}, 32'd0);

      // start together with mtlo: write dropped, LO held during CALC
      lo_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
      issue(2'b01, 32'd5, 32'd5);
      lo_wr = 1'b0;
      for (int k = 1; k < 10; k++) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("collide_lo", lo, 32'd14);
      chk("collide_busy", {31'd0, busy}, 32'd1);

      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'h0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      errs = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) errs++;
      end
      chk("abort_no_done", errs, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit with its own sequencing FSM, HI/LO result registers and a pipeline stall request. Sits beside the EX-stage ALU. Its inputs:
- The ID/EX control path issues `mult`, `multu`, `div` and `divu` to it.
- `mfhi`/`mflo` read its results.
- `mthi`/`mtlo` write its results.

While an operation is in flight it raises `stall` to freeze the IF/ID/EX stages whenever a dependent HI/LO instruction reaches EX.

## Interface
Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle issue strobe from EX for funct 0x18–0x1B
- op  in  2  00 `mult`, 01 `multu`, 10 `div`, 11 `divu`
- a  in  XLEN  rs operand (multiplicand / dividend)
- b  in  XLEN  rt operand (multiplier / divisor)
- hilo_rd  in  1  `mfhi` or `mflo` in EX this cycle
- hi_wr  in  1  `mthi` in EX
- lo_wr  in  1  `mtlo` in EX
- wr_data  in  XLEN  data for `mthi`/`mtlo`
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- stall  out  1  pipeline freeze request; combinational

## Operation
FSM states: IDLE, CALC, FIXUP.

- **IDLE**
  - `start` = 1 latches `op`, `a`, `b`.
  - Signed ops latch magnitudes plus sign flags.
  - Loads the 6-bit counter with 31 and enters CALC.
  - `hi_wr`/`lo_wr` write `wr_data` into HI/LO at the clock edge.
  - If `start` and `hi_wr`/`lo_wr` arrive together, `start` wins and the write is dropped.
- **CALC**
  - One bit per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring, 32-bit remainder plus quotient shift register.
  - Counter decrements each cycle; at 0 the FSM goes to FIXUP.
- **FIXUP** (one cycle)
  - Signed multiply with operand signs differing: 64-bit two's-complement negate of the product.
  - Signed divide: quotient negated if signs differ; remainder takes the sign of the dividend.
  - HI/LO loaded: mult → HI = product[63:32], LO = product[31:0]; div → HI = remainder, LO = quotient.
  - Then returns to IDLE.
- **Divisor zero (any div op):** HI = a, LO = 32'hFFFF_FFFF; no sign fixup. Latency is unchanged.
- **Signed overflow** (0x8000_0000 / 0xFFFF_FFFF): LO = 0x8000_0000, HI = 0.
- `busy` = 1 in CALC and FIXUP.
- `stall` = `busy` & (`start` | `hilo_rd` | `hi_wr` | `lo_wr`).
  - A stalled `start`, read or write is held in EX by the pipeline and re-presented; the block ignores it while `busy`.
- `hi`/`lo` hold their old values throughout CALC/FIXUP. They change only at the FIXUP edge, or by `mthi`/`mtlo` in IDLE.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state IDLE, counter 0.
  - Reset in any state aborts the operation at the next edge with no partial HI/LO update.
- Cycle counting: `start` sampled at edge E0.
  - `busy` = 1 for cycles 1–33: 32 CALC cycles plus 1 FIXUP cycle.
  - HI/LO are updated at edge E33.
  - `done` = 1 and `busy` = 0 in cycle 34.
  - A new `start` is accepted in cycle 34 with no bubble.
- `done` is never asserted by `mthi`/`mtlo`.
- `stall` has zero latency: it follows inputs in the same cycle.
- `hilo_rd` in cycle 34 sees the new results (no stall).

## Configuration
- Macro: `MULDIV_SIGNED_EN`.
  - **Defined:** op 00/10 are signed, with magnitude conversion in IDLE and sign fixup in FIXUP.
  - **Undefined:** `op[0]` is ignored and all operations are unsigned. Sign logic is removed, but the FIXUP cycle remains so latency is identical (34 cycles) in both builds.

## Test plan
- Reset, then `multu` with `a` = 0xFFFF_FFFF, `b` = 0xFFFF_FFFF.
  - Required: `busy` cycles 1–33, `done` in cycle 34, HI = 0xFFFF_FFFE, LO = 0x0000_0001.
- `mult` -3 × 7 (signed build).
  - Required: HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB.
- `div` -7 / 2.
  - Required: LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- `divu` 100 / 0.
  - Required: LO = 0xFFFF_FFFF, HI = 100, latency still 34 cycles.
- `mflo` asserted in cycle 5 of a `divu` 100 / 7.
  - Required: `stall` high cycles 5–33, low in cycle 34 with LO = 14 and HI = 2.
  - A second `start` during `busy` raises `stall` and does not restart the FSM.
- `mthi` 0x1234 in IDLE, then `reset` asserted mid-CALC of a new `multu`.
  - Required: after the `mthi`, HI = 0x1234.
  - After reset: HI = LO = 0, `busy` = 0, `done` never pulses.
